// File: rtl/mmio_timer_if.sv
// Core data-memory port as seen by the timer: store strobe, address and data in,
// window hit and read data out.
`timescale 1ns / 1ps
interface mmio_timer_if;
    logic        memwrite;
    logic [31:0] aluout;
    logic [31:0] writedata;
    logic        sel;
    logic [31:0] rdata;

    modport master (
        output memwrite, aluout, writedata,
        input  sel, rdata
    );

    modport slave (
        input  memwrite, aluout, writedata,
        output sel, rdata
    );
endinterface

// File: rtl/mmio_timer.sv
// Memory-mapped prescaled 32-bit timer with compare match, optional auto-reload,
// sticky match flag and level interrupt.
`timescale 1ns / 1ps
module mmio_timer #(
    parameter logic [31:0] BASE_ADDR = 32'hFFFF_0000,
    parameter int unsigned PRESC_W   = 16
) (
    input  logic         clk,
    input  logic         reset,
    mmio_timer_if.slave  bus,
    output logic         irq
);
    localparam logic [PRESC_W-1:0] PcntOne = PRESC_W'(1);

    logic [2:0]         ctrl_q, ctrl_d;
    logic [PRESC_W-1:0] prescale_q, prescale_d;
    logic [PRESC_W-1:0] pcnt_q, pcnt_d;
    logic [31:0]        count_q, count_d;
    logic [31:0]        compare_q, compare_d;
    logic               flag_q, flag_d;

    logic        sel;
    logic        we;
    logic        tick;
    logic        match;
    logic [2:0]  offset;
    logic [31:0] rdata;
    logic        unused_addr_bits;

    assign sel              = (bus.aluout[31:5] == BASE_ADDR[31:5]);
    assign offset           = bus.aluout[4:2];
    assign we               = bus.memwrite & sel;
    assign tick             = ctrl_q[0] & (pcnt_q == prescale_q);
    assign match            = (count_q == compare_q);
    assign unused_addr_bits = ^bus.aluout[1:0];

    always_comb begin
        ctrl_d     = ctrl_q;
        prescale_d = prescale_q;
        pcnt_d     = pcnt_q;
        count_d    = count_q;
        compare_d  = compare_q;
        flag_d     = flag_q;

        if (ctrl_q[0]) begin
            pcnt_d = tick ? '0 : pcnt_q + PcntOne;
        end

        // Clear first so that a match in the same cycle wins.
        if (we && (offset == 3'd4) && bus.writedata[0]) begin
            flag_d = 1'b0;
        end

        if (tick) begin
            count_d = (match && ctrl_q[1]) ? '0 : count_q + 32'd1;
            if (match) begin
                flag_d = 1'b1;
            end
        end

        // Software writes override the tick results computed above.
        if (we) begin
            case (offset)
                3'd0: ctrl_d = bus.writedata[2:0];
                3'd1: begin
                    prescale_d = bus.writedata[PRESC_W-1:0];
                    pcnt_d     = '0;
                end
                3'd2: count_d   = bus.writedata;
                3'd3: compare_d = bus.writedata;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ctrl_q     <= '0;
            prescale_q <= '0;
            pcnt_q     <= '0;
            count_q    <= '0;
            compare_q  <= 32'hFFFF_FFFF;
            flag_q     <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            flag_q     <= flag_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (offset)
                3'd0: rdata[2:0]         = ctrl_q;
                3'd1: rdata[PRESC_W-1:0] = prescale_q;
                3'd2: rdata              = count_q;
                3'd3: rdata              = compare_q;
                3'd4: rdata[0]           = flag_q;
                default: rdata           = '0;
            endcase
        end
    end

    assign bus.sel   = sel;
    assign bus.rdata = rdata;
    assign irq       = flag_q & ctrl_q[2];
endmodule
